// File: rtl/wave_gen_2b.sv
// wave_gen_2b: programmable 2-bit periodic waveform source (square, sawtooth,
// triangle, mute) with a step divider, clean start/drain and phase re-sync so
// that several instances can be aligned cycle-exactly.
module wave_gen_2b #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] step_div,
    input  logic             sync_clr,
    output logic [1:0]       out_wave,
    output logic             step_tick,
    output logic             period_start,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_lat_q, div_lat_d;
    logic [1:0]       mode_lat_q, mode_lat_d;
    logic [1:0]       out_q, out_d;
    logic             tick_q, tick_d;
    logic             pstart_q, pstart_d;
    logic             load_c;

    // Sample value for a given mode and phase index.
    function automatic logic [1:0] seq_val(input logic [1:0] m, input logic [2:0] ph);
        logic [1:0] v;
        v = 2'd0;
        case (m)
            2'b00: v = (ph < 3'd2) ? 2'd3 : 2'd0;
            2'b01: v = ph[1:0];
            2'b10: begin
                case (ph)
                    3'd0:    v = 2'd0;
                    3'd1:    v = 2'd1;
                    3'd2:    v = 2'd2;
                    3'd3:    v = 2'd3;
                    3'd4:    v = 2'd2;
                    3'd5:    v = 2'd1;
                    default: v = 2'd0;
                endcase
            end
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    // Index of the final phase of a period; triangle has six phases, the rest four.
    function automatic logic [2:0] last_phase(input logic [1:0] m);
        return (m == 2'b10) ? 3'd5 : 3'd3;
    endfunction

    // Next-state logic: sequencing, divider, load events and drain handling.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        div_cnt_d  = div_cnt_q;
        div_lat_d  = div_lat_q;
        mode_lat_d = mode_lat_q;
        out_d      = out_q;
        tick_d     = 1'b0;
        pstart_d   = 1'b0;
        load_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                if (sync_clr) begin
                    // Phase restart wins over stepping; en decides run or drain.
                    load_c  = 1'b1;
                    state_d = en ? RUN : DRAIN;
                end else begin
                    state_d = en ? RUN : DRAIN;
                    if (div_cnt_q == div_lat_q) begin
                        if (phase_q == last_phase(mode_lat_q)) begin
                            if ((state_q == DRAIN) && !en) begin
                                // Period finished while draining: go quiet, no new period.
                                state_d   = IDLE;
                                phase_d   = 3'd0;
                                div_cnt_d = '0;
                                out_d     = 2'd0;
                            end else begin
                                load_c = 1'b1;
                            end
                        end else begin
                            phase_d   = phase_q + 3'd1;
                            div_cnt_d = '0;
                            out_d     = seq_val(mode_lat_q, phase_q + 3'd1);
                            tick_d    = 1'b1;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_c) begin
            phase_d    = 3'd0;
            div_cnt_d  = '0;
            mode_lat_d = mode;
            div_lat_d  = step_div;
            out_d      = seq_val(mode, 3'd0);
            pstart_d   = 1'b1;
            tick_d     = 1'b1;
        end
    end

    // State and output registers; asynchronous reset aborts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= 3'd0;
            div_cnt_q  <= '0;
            div_lat_q  <= '0;
            mode_lat_q <= 2'b00;
            out_q      <= 2'd0;
            tick_q     <= 1'b0;
            pstart_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            div_cnt_q  <= div_cnt_d;
            div_lat_q  <= div_lat_d;
            mode_lat_q <= mode_lat_d;
            out_q      <= out_d;
            tick_q     <= tick_d;
            pstart_q   <= pstart_d;
        end
    end

    assign out_wave     = out_q;
    assign step_tick    = tick_q;
    assign period_start = pstart_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_wave_gen_2b.sv
// Testbench for wave_gen_2b: two instances driven by directed and random
// stimulus, compared each cycle against a period-buffer reference model.
module tb_wave_gen_2b;

    logic       clk;
    logic       rst_n;
    logic       sc;
    logic       en0, en1;
    logic [1:0] mode0, mode1;
    logic [7:0] div0, div1;
    logic [1:0] out0, out1;
    logic       tick0, tick1, ps0, ps1, busy0, busy1;

    int errors = 0;
    int checks = 0;
    string tname = "init";

    wave_gen_2b #(.DIV_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .mode(mode0), .step_div(div0),
        .sync_clr(sc), .out_wave(out0), .step_tick(tick0),
        .period_start(ps0), .busy(busy0)
    );

    wave_gen_2b #(.DIV_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .step_div(div1),
        .sync_clr(sc), .out_wave(out1), .step_tick(tick1),
        .period_start(ps1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: on each load the whole period is unrolled into a
    // per-cycle list of expected {value, step_tick, period_start}.
    typedef struct packed {
        logic [1:0] v;
        logic       t;
        logic       p;
    } ent_t;

    ent_t pbuf [2][0:1535];
    int   plen [2];
    int   ppos [2];
    bit   mbusy [2];
    bit   mdrain [2];
    logic [1:0] eo [2];
    logic       et [2];
    logic       ep [2];

    logic [1:0] sq_tab  [4] = '{2'd3, 2'd3, 2'd0, 2'd0};
    logic [1:0] saw_tab [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] tri_tab [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};

    function automatic logic [1:0] seq_at(input logic [1:0] m, input int ph);
        case (m)
            2'b00:   return sq_tab[ph];
            2'b01:   return saw_tab[ph];
            2'b10:   return tri_tab[ph];
            default: return 2'd0;
        endcase
    endfunction

    task automatic m_load(input int i, input logic [1:0] m, input int d);
        int n;
        n = (m == 2'b10) ? 6 : 4;
        plen[i] = 0;
        for (int ph = 0; ph < n; ph++) begin
            for (int c = 0; c <= d; c++) begin
                pbuf[i][plen[i]] = '{v: seq_at(m, ph), t: (c == 0), p: (c == 0 && ph == 0)};
                plen[i]++;
            end
        end
        ppos[i] = 0;
    endtask

    task automatic m_pop(input int i);
        eo[i] = pbuf[i][ppos[i]].v;
        et[i] = pbuf[i][ppos[i]].t;
        ep[i] = pbuf[i][ppos[i]].p;
        ppos[i]++;
    endtask

    task automatic m_quiet(input int i);
        mbusy[i]  = 0;
        mdrain[i] = 0;
        eo[i] = 2'd0;
        et[i] = 1'b0;
        ep[i] = 1'b0;
        plen[i] = 0;
        ppos[i] = 0;
    endtask

    task automatic m_edge(input int i, input logic e, input logic [1:0] m, input int d, input logic s);
        if (!mbusy[i]) begin
            if (e) begin
                m_load(i, m, d);
                mbusy[i]  = 1;
                mdrain[i] = 0;
                m_pop(i);
            end else begin
                et[i] = 1'b0;
                ep[i] = 1'b0;
            end
        end else if (s) begin
            m_load(i, m, d);
            mdrain[i] = !e;
            m_pop(i);
        end else if (ppos[i] == plen[i]) begin
            if (mdrain[i] && !e) begin
                m_quiet(i);
            end else begin
                m_load(i, m, d);
                mdrain[i] = !e;
                m_pop(i);
            end
        end else begin
            mdrain[i] = !e;
            m_pop(i);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0d expected=%0d", tname, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out0",  int'(out0),  int'(eo[0]));
        chk("tick0", int'(tick0), int'(et[0]));
        chk("ps0",   int'(ps0),   int'(ep[0]));
        chk("busy0", int'(busy0), int'(mbusy[0]));
        chk("out1",  int'(out1),  int'(eo[1]));
        chk("tick1", int'(tick1), int'(et[1]));
        chk("ps1",   int'(ps1),   int'(ep[1]));
        chk("busy1", int'(busy1), int'(mbusy[1]));
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (rst_n) begin
                m_edge(0, en0, mode0, int'(div0), sc);
                m_edge(1, en1, mode1, int'(div1), sc);
            end else begin
                m_quiet(0);
                m_quiet(1);
            end
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sc = 1'b0;
        en0 = 1'b0; en1 = 1'b0;
        mode0 = 2'b00; mode1 = 2'b00;
        div0 = 8'd0; div1 = 8'd0;
        m_quiet(0);
        m_quiet(1);

        #2;
        tname = "reset";
        check_all();
        step(2);
        rst_n = 1'b1;
        step(2);

        // Sawtooth at step_div=2 on u0, triangle at step_div=0 on u1.
        tname = "saw_tri";
        mode0 = 2'b01; div0 = 8'd2; en0 = 1'b1;
        mode1 = 2'b10; div1 = 8'd0; en1 = 1'b1;
        step(28);

        // Mid-period mode/divider changes apply from the next period only.
        tname = "latch";
        mode0 = 2'b10; div0 = 8'd0;
        mode1 = 2'b00;
        step(26);

        // Asynchronous reset mid-run, checked before any clock edge.
        tname = "async_rst";
        #3;
        rst_n = 1'b0;
        #1;
        m_quiet(0);
        m_quiet(1);
        check_all();
        step(2);
        rst_n = 1'b1;
        mode0 = 2'b01; div0 = 8'd1;
        step(12);

        // Drain: drop en at sawtooth phase 1, then a re-raise during drain.
        tname = "drain";
        sc = 1'b1;
        step(1);
        sc = 1'b0;
        step(2);
        en0 = 1'b0;
        step(12);
        en0 = 1'b1;
        step(3);
        en0 = 1'b0;
        step(2);
        en0 = 1'b1;
        step(12);

        // Common sync_clr aligns two instances running at different phases.
        tname = "sync";
        mode0 = 2'b01; div0 = 8'd1;
        mode1 = 2'b01; div1 = 8'd1;
        step(3);
        sc = 1'b1;
        step(1);
        sc = 1'b0;
        step(10);

        // sync_clr while idle has no effect.
        tname = "sync_idle";
        en0 = 1'b0; en1 = 1'b0;
        step(20);
        sc = 1'b1;
        step(1);
        sc = 1'b0;
        step(3);

        // Random stimulus, mute included.
        tname = "random";
        for (int r = 0; r < 500; r++) begin
            if ($urandom_range(0, 9) == 0) en0 = ~en0;
            if ($urandom_range(0, 9) == 0) en1 = ~en1;
            if ($urandom_range(0, 3) == 0) mode0 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) mode1 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) div0 = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) div1 = 8'($urandom_range(0, 3));
            sc = ($urandom_range(0, 29) == 0);
            step(1);
        end
        sc = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
